sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-to-parallel receiver for the single-bit data stream our sequential cells produce and consume.
- Samples one bit per qualified clock edge, frames bits into WIDTH-bit words using a start marker, and presents each word on a valid/ready output port.
- Sits between a serial bit source (flop chain, shift-out stage) and parallel consumer logic.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0].

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sin_en  input  1  sin is valid this cycle; bits are sampled only when sin_en=1.
- sync  input  1  start-of-word marker, qualified by sin_en; marks sin as bit 0 of a new word.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1.
- frame_err  output  1  one-cycle pulse when a partial word is aborted.
- overflow  output  1  sticky: a completed word was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, bit counter=0, shift register=0.
  - dout=0, dout_valid=0, frame_err=0, overflow=0.
  - A partial word is discarded.
- States:
  - IDLE: sin_en=1 and sync=1 -> capture sin as bit 0, cnt=1, go to SHIFT. sin_en=1 with sync=0 -> bit ignored. Otherwise stay.
  - SHIFT: sin_en=1 and sync=0 -> shift in sin, cnt+1. When the WIDTH-th bit is accepted, transfer the word to the output register and go to IDLE (PARITY if the feature is enabled). sin_en=0 -> hold, no timeout.
  - SHIFT, sync=1 with sin_en=1: partial word aborted, frame_err=1 for one cycle, sin taken as bit 0 of a new word, cnt=1, stay in SHIFT.
- Latency: dout_valid rises in the cycle after the edge that samples the last bit. Back-to-back words are accepted with zero dead cycles.
- Bit order: MSB_FIRST=1 shifts left (each new bit enters at LSB). MSB_FIRST=0 shifts right (each new bit enters at MSB).
- Output handshake:
  - dout and dout_valid are held stable until a cycle with dout_valid=1 and dout_ready=1.
  - On that handshake, dout_valid drops next cycle unless a new word completes in the same cycle.
  - Same-cycle completion and handshake: new word loaded, dout_valid stays 1, no overflow.
  - Completion while dout_valid=1 and dout_ready=0: new word dropped, dout unchanged, overflow set.
- overflow is cleared only by clr_ovf=1 or reset. clr_ovf and a new overflow in the same cycle: overflow stays set.
- dout_ready is ignored while dout_valid=0.

Optional Feature:
- Macro: SIPO_PARITY_CHK_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY and expects one more sin_en bit carrying even parity over the word.
  - The word is presented with the parity check result; output parity_err (1 bit) is valid alongside dout_valid and is held with dout.
  - sync in PARITY aborts the word, same as in SHIFT.
- Not defined: no PARITY state, no parity_err port, word completes after WIDTH bits.

Decomposition:
- Package sipo_pkg: state enum (IDLE, SHIFT, PARITY), counter width constant clog2(WIDTH+1), and the WIDTH legal-range limits.
- One sub-module, sipo_shreg: parameterised shift register with load-first-bit, shift enable, and direction select. The FSM, counter, and output register stay in the top level.

Test Plan (WIDTH=8, MSB_FIRST=1 unless noted):
- Reset, then sync+sin_en with bit stream 1,0,1,0,0,1,1,0 and dout_ready=1 -> dout=8'hA6 and dout_valid high exactly one cycle after the 8th bit, then low.
- Same stream with MSB_FIRST=0 -> dout=8'h65.
- Two back-to-back words 8'hA6, 8'h3C with dout_ready=0 -> dout stays 8'hA6, overflow=1. Pulse clr_ovf -> overflow=0.
- sync reasserted after 3 bits, then a full new word 8'hFF -> frame_err pulses once, dout=8'hFF.
- Drop reset low mid-word after 4 bits -> all outputs 0 immediately, without waiting for a clock edge. The next full word is received correctly.
- With SIPO_PARITY_CHK_EN: word 8'hA6 followed by parity bit 0 -> parity_err=0. Same word followed by parity bit 1 -> parity_err=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and limits for the sipo_deser receiver.
// Holds the FSM state enum, the WIDTH legal range and counter sizing.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int WIDTH_DEF = 8;

  // Bit counter must hold the value WIDTH itself.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial-in and word-out bundle of sipo_deser.
// master = bit source / word consumer side, slave = the receiver.
// With SIPO_PARITY_CHK_EN the bundle also carries parity_err.
interface sipo_deser_if #(
  parameter int WIDTH = 8
);

  logic             sin;
  logic             sin_en;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overflow;
  logic             clr_ovf;
`ifdef SIPO_PARITY_CHK_EN
  logic             parity_err;
`endif

`ifdef SIPO_PARITY_CHK_EN
  modport master (
    output sin, sin_en, sync,
    output dout_ready, clr_ovf,
    input  dout, dout_valid,
    input  frame_err, overflow,
    input  parity_err
  );

  modport slave (
    input  sin, sin_en, sync,
    input  dout_ready, clr_ovf,
    output dout, dout_valid,
    output frame_err, overflow,
    output parity_err
  );
`else
  modport master (
    output sin, sin_en, sync,
    output dout_ready, clr_ovf,
    input  dout, dout_valid,
    input  frame_err, overflow
  );

  modport slave (
    input  sin, sin_en, sync,
    input  dout_ready, clr_ovf,
    output dout, dout_valid,
    output frame_err, overflow
  );
`endif

endinterface

// File: rtl/sipo_shreg.sv
// sipo_shreg: word assembly shift register for sipo_deser.
// Ports: clk, reset (async low), load (first bit, clears the
// rest), shift, din, q_nxt (combinational next value).
// MSB_FIRST=1 shifts left, new bits enter at the LSB;
// MSB_FIRST=0 shifts right, new bits enter at the MSB.
module sipo_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH-1:0] q;

  // q_nxt equals q whenever neither load nor shift is set,
  // so it also serves as the held-word view.
  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = MSB_FIRST
            ? {{(WIDTH-1){1'b0}}, din}
            : {din, {(WIDTH-1){1'b0}}};
    end else if (shift) begin
      q_nxt = MSB_FIRST
            ? {q[WIDTH-2:0], din}
            : {din, q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel receiver with start-marker framing.
// Ports: clk, reset (async low), bus (sipo_deser_if.slave):
//   sin/sin_en/sync in, dout/dout_valid/dout_ready word port,
//   frame_err pulse, sticky overflow with clr_ovf.
// SIPO_PARITY_CHK_EN: adds a PARITY state taking one even-parity
// bit after each word and reports parity_err with dout.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  sipo_deser_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("sipo_deser: WIDTH out of range");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             fe_q;
  logic             ovf_q;

  logic start;
  logic bit_in;
  logic last;
  logic load;
  logic shift;
  logic done;
  logic abort;
  logic take;

  assign start  = bus.sin_en & bus.sync;
  assign bit_in = bus.sin_en & ~bus.sync;
  assign last   = (cnt == CW'(WIDTH - 1));

  sipo_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (bus.sin),
    .q_nxt (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
`ifdef SIPO_PARITY_CHK_EN
        if (bit_in && last) state_nxt = PARITY;
`else
        if (bit_in && last) state_nxt = IDLE;
`endif
      end
      PARITY: begin
        if (start)       state_nxt = SHIFT;
        else if (bit_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A sync bit always restarts framing; outside IDLE it also
  // throws away the partial word.
  always_comb begin
    load  = start;
    shift = 1'b0;
    done  = 1'b0;
    abort = 1'b0;
    unique case (state)
      IDLE: ;
      SHIFT: begin
        abort = start;
        shift = bit_in;
`ifndef SIPO_PARITY_CHK_EN
        done  = bit_in & last;
`endif
      end
      PARITY: begin
        abort = start;
        done  = bit_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(1);
    end else if (shift) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A word completing in the same cycle as a handshake
  // replaces the consumed one without a gap.
  assign take = done & (~valid_q | bus.dout_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      fe_q  <= abort;
      ovf_q <= (done & ~take)
             | (ovf_q & ~bus.clr_ovf);
      if (take) begin
        dout_q  <= word;
        valid_q <= 1'b1;
      end else if (valid_q && bus.dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_CHK_EN
  logic perr_q;

  // Even parity: data ones plus parity bit must be even.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else if (take) begin
      perr_q <= (^word) ^ bus.sin;
    end
  end

  assign bus.parity_err = perr_q;
`endif

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = fe_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: vector table plus scoreboard bench for sipo_deser.
// Runs MSB_FIRST=1 and MSB_FIRST=0 instances on the same stimulus.
module tb_sipo_deser;

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  typedef struct {
    logic [7:0] m;
    logic [7:0] l;
    logic       p;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   fe_cnt;
  exp_t sb[$];
  vec_t tbl[5];

  sipo_deser_if #(.WIDTH(8)) bus ();
  sipo_deser_if #(.WIDTH(8)) bus_l ();

  sipo_deser #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sipo_deser #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0)
  ) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(
    input string       n,
    input logic [31:0] a,
    input logic [31:0] e
  );
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (reset && bus.frame_err) fe_cnt++;
    if (reset && bus.dout_valid && bus.dout_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none",
                 bus.dout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout_msb", {24'd0, bus.dout}, {24'd0, e.m});
        chk("dout_lsb", {24'd0, bus_l.dout}, {24'd0, e.l});
        chk("valid_lsb", {31'd0, bus_l.dout_valid}, 32'd1);
`ifdef SIPO_PARITY_CHK_EN
        chk("parity_err", {31'd0, bus.parity_err},
            {31'd0, e.p});
`endif
      end
    end
  end

  task automatic drv(input logic s, input logic en,
                     input logic sy);
    bus.sin     = s;
    bus.sin_en  = en;
    bus.sync    = sy;
    bus_l.sin    = s;
    bus_l.sin_en = en;
    bus_l.sync   = sy;
  endtask

  task automatic set_rdy(input logic r);
    bus.dout_ready   = r;
    bus_l.dout_ready = r;
  endtask

  task automatic set_clr(input logic c);
    bus.clr_ovf   = c;
    bus_l.clr_ovf = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sy);
    drv(b, 1'b1, sy);
    tick();
  endtask

  task automatic idle(input int n);
    drv(1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic push(input logic [7:0] m,
                      input logic [7:0] l,
                      input logic p);
    exp_t e;
    e.m = m;
    e.l = l;
    e.p = p;
    sb.push_back(e);
  endtask

  // Sends w MSB first with sync on the first bit. rdy_last raises
  // dout_ready just before the completing bit.
  task automatic send_word(input logic [7:0] w,
                           input logic pflip,
                           input bit rdy_last);
    for (int i = 7; i >= 0; i--) begin
`ifndef SIPO_PARITY_CHK_EN
      if (i == 0 && rdy_last) set_rdy(1'b1);
`endif
      send_bit(w[i], i == 7);
    end
`ifdef SIPO_PARITY_CHK_EN
    if (rdy_last) set_rdy(1'b1);
    send_bit((^w) ^ pflip, 1'b0);
`else
    if (pflip) drv(1'b0, 1'b0, 1'b0);
`endif
    drv(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fe_cnt = 0;
    tbl[0] = '{8'hA6, 8'hA6, 8'h65};
    tbl[1] = '{8'h01, 8'h01, 8'h80};
    tbl[2] = '{8'h12, 8'h12, 8'h48};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{8'h3C, 8'h3C, 8'h3C};

    reset = 1'b0;
    drv(1'b0, 1'b0, 1'b0);
    set_rdy(1'b0);
    set_clr(1'b0);
    tick();
    tick();
    chk("rst_dout", {24'd0, bus.dout}, 32'd0);
    chk("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b1;
    tick();

    // latency: valid one cycle after the last bit, then low
    set_rdy(1'b1);
    push(8'hA6, 8'h65, 1'b0);
    send_word(8'hA6, 1'b0, 1'b0);
    chk("lat_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("lat_dout", {24'd0, bus.dout}, 32'hA6);
    chk("lat_dout_l", {24'd0, bus_l.dout}, 32'h65);
    idle(1);
    chk("lat_drop", {31'd0, bus.dout_valid}, 32'd0);

    // back-to-back table words
    for (int i = 0; i < 5; i++) begin
      push(tbl[i].exp_msb, tbl[i].exp_lsb, 1'b0);
      send_word(tbl[i].word, 1'b0, 1'b0);
    end
    idle(3);
    chk("tbl_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("tbl_fe", fe_cnt, 32'd0);

    // overflow when consumer stalls
    set_rdy(1'b0);
    push(8'hA6, 8'h65, 1'b0);
    send_word(8'hA6, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    idle(2);
    chk("ovf_dout", {24'd0, bus.dout}, 32'hA6);
    chk("ovf_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
    idle(3);
    chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    set_clr(1'b1);
    tick();
    set_clr(1'b0);
    chk("ovf_clr", {31'd0, bus.overflow}, 32'd0);
    set_rdy(1'b1);
    idle(2);
    chk("drain_valid", {31'd0, bus.dout_valid}, 32'd0);

    // completion coincides with handshake
    set_rdy(1'b0);
    push(8'hA6, 8'h65, 1'b0);
    send_word(8'hA6, 1'b0, 1'b0);
    push(8'h12, 8'h48, 1'b0);
    send_word(8'h12, 1'b0, 1'b1);
    chk("same_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("same_dout", {24'd0, bus.dout}, 32'h12);
    chk("same_ovf", {31'd0, bus.overflow}, 32'd0);
    idle(2);

    // sync after 3 bits aborts the partial word
    push(8'hFF, 8'hFF, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0);
    idle(2);
    chk("fe_once", fe_cnt, 32'd1);
    chk("fe_low", {31'd0, bus.frame_err}, 32'd0);

    // asynchronous reset mid-word
    set_rdy(1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("pre_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("pre_ovf", {31'd0, bus.overflow}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_dout", {24'd0, bus.dout}, 32'd0);
    chk("arst_dout_l", {24'd0, bus_l.dout}, 32'd0);
    chk("arst_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("arst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("arst_fe", {31'd0, bus.frame_err}, 32'd0);
    idle(2);
    reset = 1'b1;
    tick();
    set_rdy(1'b1);
    push(8'hC3, 8'hC3, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    idle(3);

`ifdef SIPO_PARITY_CHK_EN
    push(8'hA6, 8'h65, 1'b0);
    send_word(8'hA6, 1'b0, 1'b0);
    chk("par_ok", {31'd0, bus.parity_err}, 32'd0);
    push(8'hA6, 8'h65, 1'b1);
    send_word(8'hA6, 1'b1, 1'b0);
    chk("par_bad", {31'd0, bus.parity_err}, 32'd1);
    idle(3);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
